// File: rtl/simple_serial_rx_pkg.sv
// simple_serial_rx_pkg: shared FSM state type, default sizes and width helpers.
package simple_serial_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
  localparam int DATA_W_DEF     = 8;
  localparam int BIT_CYCLES_DEF = 4;
  localparam int CNT_W_DEF      = 8;
  function automatic int half_bit(input int bit_cycles);
    return bit_cycles / 2;
  endfunction
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sync2_bit.sv
// sync2_bit: two-flop synchronizer with a configurable reset value.
module sync2_bit #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/simple_serial_rx.sv
// simple_serial_rx: framed serial receiver with a one-entry valid/ready holding register.
module simple_serial_rx
  import simple_serial_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              tau2015_clk,
  input  logic              tau2015_rst_n,
  input  logic              ser_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic              busy
);
  localparam int HALF  = half_bit(BIT_CYCLES);
  localparam int CYC_W = cnt_w(BIT_CYCLES);
  localparam int BIT_W = cnt_w(DATA_W + 1);

  if (BIT_CYCLES < 2 || BIT_CYCLES % 2 != 0) begin : g_chk_bc
    $error("BIT_CYCLES must be even and >= 2");
  end
  if (DATA_W < 1) begin : g_chk_dw
    $error("DATA_W must be >= 1");
  end

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
  logic              valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ln, tick_half, tick_bit, stop_smp, good, load;

  sync2_bit #(.RST_VAL(1'b1)) u_sync (
    .clk  (tau2015_clk),
    .rst_n(tau2015_rst_n),
    .d    (ser_in),
    .q    (ln)
  );

  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
    if (!tau2015_rst_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  assign tick_half = cyc_q == CYC_W'(HALF - 1);
  assign tick_bit  = cyc_q == CYC_W'(BIT_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!ln) state_d = START;
      START:   if (tick_half) state_d = ln ? IDLE : DATA;
      DATA:    if (tick_bit && bit_q == BIT_W'(DATA_W - 1)) state_d = STOP;
      STOP:    if (tick_bit) state_d = ln ? IDLE : WAIT_HI;
      WAIT_HI: if (ln) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = state_q != IDLE;
  end

  // A good frame is loaded when the register is empty or drained in the same cycle.
  always_comb begin
    stop_smp = state_q == STOP && tick_bit;
    good     = stop_smp & ln;
    load     = good & (~valid_q | rx_ready);
    cyc_d    = (state_q == IDLE || (state_q == START && tick_half) || tick_bit) ? '0 : cyc_q + 1'b1;
    bit_d    = (state_q == DATA) ? (tick_bit ? bit_q + 1'b1 : bit_q) : '0;
    sh_d     = (state_q == DATA && tick_bit) ? (sh_q >> 1) | (DATA_W'(ln) << (DATA_W - 1)) : sh_q;
    data_d   = load ? sh_q : data_q;
    valid_d  = load | (valid_q & ~rx_ready);
    ferr_d   = stop_smp & ~ln;
    ovr_d    = good & valid_q & ~rx_ready;
    cnt_d    = (ovr_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
    if (!tau2015_rst_n) begin
      cyc_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign ovf_cnt   = cnt_q;
endmodule
